// File: rtl/riscv_pkg.sv
// Shared branch-condition definitions: funct[11:8] codes used by both the
// branch detector and the flag unit, plus the flag unit's state encoding.
package riscv_pkg;

    // Branch funct[11:8] codes
    localparam logic [3:0] FN_BEQ = 4'b0000;
    localparam logic [3:0] FN_BNE = 4'b0001;
    localparam logic [3:0] FN_BCS = 4'b0010;
    localparam logic [3:0] FN_BCC = 4'b0011;
    localparam logic [3:0] FN_BAL = 4'b1110;

    // Flag unit control state
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        ERR  = 2'b10
    } flag_state_e;

    // True for branches whose outcome depends on the carry/zero flags.
    // BAL and any non-branch funct do not read the flags.
    function automatic logic is_flag_branch(input logic [3:0] funct);
        logic hit;
        hit = 1'b0;
        case (funct)
            FN_BEQ, FN_BNE, FN_BCS, FN_BCC: hit = 1'b1;
            default:                        hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/flag_pending_ctr.sv
// Saturating up/down counter of in-flight flag-setting ops. An issue and a
// writeback in the same cycle cancel. Stepping past either end holds the
// count and raises a one-cycle overflow/underflow pulse for the caller.
module flag_pending_ctr
    import riscv_pkg::*;
#(
    parameter int unsigned MAX_PENDING = 3,
    localparam int unsigned CW         = $clog2(MAX_PENDING + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          overflow,
    output logic          underflow
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          step_up;
    logic          step_dn;

    // Decode net step and detect out-of-range moves before they happen
    always_comb begin
        step_up   = inc & ~dec;
        step_dn   = dec & ~inc;
        overflow  = step_up && (count_q == CW'(MAX_PENDING));
        underflow = step_dn && (count_q == '0);
        count_d   = count_q;
        if (step_up && !overflow) begin
            count_d = count_q + 1'b1;
        end else if (step_dn && !underflow) begin
            count_d = count_q - 1'b1;
        end
    end

    // Count register, cleared by reset so in-flight accounting is discarded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/branch_flag_unit.sv
// Producer side of the branch-condition interface. Holds the architectural
// carry/zero flags, drives complementary flag pairs to the condition decoder,
// forwards a same-cycle writeback, and holds off flag branches while older
// flag-setting ops are still in flight.
module branch_flag_unit
    import riscv_pkg::*;
#(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned MAX_PENDING = 3,
    localparam int unsigned CW         = $clog2(MAX_PENDING + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_fset,
    input  logic             wb_fset,
    input  logic             wb_carry,
    input  logic [WIDTH-1:0] wb_result,
    input  logic             br_valid,
    input  logic [3:0]       br_funct,
    output logic             br_ready,
    output logic             br_stall,
    output logic             C0,
    output logic             C1,
    output logic             Z0,
    output logic             Z1,
    output logic [CW-1:0]    pending,
    output logic             flag_err
);

    logic        carry_q;
    logic        zero_q;
    logic        wb_zero;
    logic        cur_carry;
    logic        cur_zero;
    logic        ctr_ovf;
    logic        ctr_unf;
    logic        proto_err;
    logic        flag_br;
    logic        fwd_ok;
    flag_state_e state_q;

    assign wb_zero   = (wb_result == {WIDTH{1'b0}});
    assign proto_err = ctr_ovf | ctr_unf;

    flag_pending_ctr #(
        .MAX_PENDING (MAX_PENDING)
    ) u_pending_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (issue_fset),
        .dec       (wb_fset),
        .count     (pending),
        .overflow  (ctr_ovf),
        .underflow (ctr_unf)
    );

    // Architectural flags: loaded on every flag-setting writeback, even in ERR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else if (wb_fset) begin
            carry_q <= wb_carry;
            zero_q  <= wb_zero;
        end
    end

    // Forward writeback flags in the same cycle so the branch sees them early
    always_comb begin
        cur_carry = carry_q;
        cur_zero  = zero_q;
        if (wb_fset) begin
            cur_carry = wb_carry;
            cur_zero  = wb_zero;
        end
        C1 = cur_carry;
        C0 = ~cur_carry;
        Z1 = cur_zero;
        Z0 = ~cur_zero;
    end

    // Control FSM with sticky error; ERR is left only through reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            flag_err <= 1'b0;
        end else begin
            if (proto_err) begin
                flag_err <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (proto_err) begin
                        state_q <= ERR;
                    end else if (issue_fset && !wb_fset) begin
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (proto_err) begin
                        state_q <= ERR;
                    end else if ((pending == CW'(1)) && wb_fset && !issue_fset) begin
                        state_q <= IDLE;
                    end
                end
                ERR: begin
                    state_q <= ERR;
                end
                default: begin
                    state_q <= ERR;
                end
            endcase
        end
    end

    // Branch readiness: a same-cycle issue is younger than the branch, so only
    // the oldest outstanding op writing back now can make the flags current.
    always_comb begin
        flag_br  = is_flag_branch(br_funct);
        fwd_ok   = (pending == CW'(1)) && wb_fset;
        br_ready = 1'b1;
        if (flag_br) begin
            if (state_q == ERR) begin
                br_ready = 1'b0;
            end else begin
                br_ready = (pending == '0) || fwd_ok;
            end
        end
        br_stall = br_valid & ~br_ready;
    end

endmodule

// File: tb/tb_branch_flag_unit.sv
// Directed bench for branch_flag_unit with a behavioural reference model.
module tb_branch_flag_unit;
    import riscv_pkg::*;

    localparam int unsigned WIDTH       = 16;
    localparam int unsigned MAX_PENDING = 3;
    localparam int unsigned CW          = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             issue_fset = 1'b0;
    logic             wb_fset = 1'b0;
    logic             wb_carry = 1'b0;
    logic [WIDTH-1:0] wb_result = '0;
    logic             br_valid = 1'b0;
    logic [3:0]       br_funct = 4'h0;
    logic             br_ready;
    logic             br_stall;
    logic             C0, C1, Z0, Z1;
    logic [CW-1:0]    pending;
    logic             flag_err;

    branch_flag_unit #(
        .WIDTH       (WIDTH),
        .MAX_PENDING (MAX_PENDING)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue_fset (issue_fset),
        .wb_fset    (wb_fset),
        .wb_carry   (wb_carry),
        .wb_result  (wb_result),
        .br_valid   (br_valid),
        .br_funct   (br_funct),
        .br_ready   (br_ready),
        .br_stall   (br_stall),
        .C0         (C0),
        .C1         (C1),
        .Z0         (Z0),
        .Z1         (Z1),
        .pending    (pending),
        .flag_err   (flag_err)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model state
    int m_pend;
    bit m_carry, m_zero, m_err, m_dead;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: count of older ops, sticky error, flags from last writeback
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend  <= 0;
            m_carry <= 1'b0;
            m_zero  <= 1'b0;
            m_err   <= 1'b0;
            m_dead  <= 1'b0;
        end else begin
            if (issue_fset && !wb_fset) begin
                if (m_pend == int'(MAX_PENDING)) begin
                    m_err  <= 1'b1;
                    m_dead <= 1'b1;
                end else begin
                    m_pend <= m_pend + 1;
                end
            end
            if (wb_fset && !issue_fset) begin
                if (m_pend == 0) begin
                    m_err  <= 1'b1;
                    m_dead <= 1'b1;
                end else begin
                    m_pend <= m_pend - 1;
                end
            end
            if (wb_fset) begin
                m_carry <= wb_carry;
                m_zero  <= (wb_result == 0);
            end
        end
    end

    bit e_c, e_z, e_rdy;

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (rst_n) begin
            e_c = wb_fset ? wb_carry : m_carry;
            e_z = wb_fset ? (wb_result == 0) : m_zero;
            if (br_funct > 4'd3)       e_rdy = 1'b1;
            else if (m_dead)           e_rdy = 1'b0;
            else                       e_rdy = (m_pend == 0) || (m_pend == 1 && wb_fset);
            chk("C1", C1, e_c);
            chk("C0", C0, !e_c);
            chk("Z1", Z1, e_z);
            chk("Z0", Z0, !e_z);
            chk("br_ready", br_ready, e_rdy);
            chk("br_stall", br_stall, br_valid && !e_rdy);
            chk("pending", pending, m_pend);
            chk("flag_err", flag_err, m_err);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic is, input logic wb, input logic wc,
                         input logic [WIDTH-1:0] res, input logic bv, input logic [3:0] fn);
        issue_fset = is;
        wb_fset    = wb;
        wb_carry   = wc;
        wb_result  = res;
        br_valid   = bv;
        br_funct   = fn;
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        // Reset values
        chk("rst_C0", C0, 1); chk("rst_C1", C1, 0); chk("rst_Z0", Z0, 1); chk("rst_Z1", Z1, 0);
        chk("rst_pending", pending, 0); chk("rst_err", flag_err, 0);

        // One op in flight stalls BEQ until its writeback is forwarded
        cyc(); drive(1, 0, 0, 16'h0000, 0, FN_BEQ);
        chk("t2_pend0", pending, 0);
        cyc(); drive(0, 0, 0, 16'h0000, 1, FN_BEQ);
        chk("t2_pend1", pending, 1); chk("t2_stall", br_stall, 1);
        cyc(); #1;
        chk("t2_stall_hold", br_stall, 1);
        cyc(); drive(0, 1, 1, 16'h0000, 1, FN_BEQ);
        chk("t2_fwd_ready", br_ready, 1); chk("t2_fwd_Z1", Z1, 1); chk("t2_fwd_C1", C1, 1);
        cyc(); drive(0, 0, 0, 16'hffff, 0, FN_BEQ);
        chk("t2_pend_done", pending, 0); chk("t2_reg_C1", C1, 1); chk("t2_reg_Z1", Z1, 1);

        // Two in flight: BNE waits for the second writeback
        cyc(); drive(1, 0, 0, 16'h0000, 0, FN_BNE);
        cyc(); drive(1, 0, 0, 16'h0000, 0, FN_BNE);
        cyc(); drive(0, 0, 0, 16'h0000, 1, FN_BNE);
        chk("t3_pend2", pending, 2); chk("t3_stall", br_stall, 1);
        cyc(); drive(0, 1, 0, 16'h0005, 1, FN_BNE);
        chk("t3_wb1_stall", br_stall, 1); chk("t3_wb1_C1", C1, 0); chk("t3_wb1_Z1", Z1, 0);
        cyc(); #1;
        chk("t3_wb2_pend", pending, 1); chk("t3_wb2_ready", br_ready, 1); chk("t3_wb2_Z0", Z0, 1);
        cyc(); drive(0, 0, 0, 16'h0000, 0, FN_BNE);
        chk("t3_pend0", pending, 0);

        // Issue and writeback together at pending=1
        cyc(); drive(1, 0, 0, 16'h0000, 0, FN_BAL);
        cyc(); drive(1, 1, 1, 16'h0000, 1, FN_BAL);
        chk("t4_pend", pending, 1);
        cyc(); drive(0, 0, 0, 16'h1234, 1, FN_BCC);
        chk("t4_pend_hold", pending, 1); chk("t4_C1", C1, 1); chk("t4_Z1", Z1, 1);
        chk("t4_bcc_stall", br_stall, 1);
        cyc(); #1;
        chk("t4_bcc_stall2", br_stall, 1);
        cyc(); drive(0, 1, 0, 16'h1234, 1, FN_BCC);
        chk("t4_bcc_ready", br_ready, 1); chk("t4_C0", C0, 1);
        cyc(); drive(0, 0, 0, 16'h0000, 0, FN_BCC);
        chk("t4_pend0", pending, 0);

        // BAL ignores a full pipeline of flag ops
        repeat (3) begin cyc(); drive(1, 0, 0, 16'h0000, 0, FN_BAL); end
        cyc(); drive(0, 0, 0, 16'h0000, 1, FN_BAL);
        chk("t5_pend3", pending, 3); chk("t5_bal_ready", br_ready, 1); chk("t5_bal_stall", br_stall, 0);
        cyc(); drive(0, 0, 0, 16'h0000, 1, FN_BEQ);
        chk("t5_beq_stall", br_stall, 1);

        // Overflow: fourth issue saturates and latches the error
        cyc(); drive(1, 0, 0, 16'h0000, 1, FN_BEQ);
        chk("t6_err_before", flag_err, 0);
        cyc(); drive(0, 0, 0, 16'h0000, 1, FN_BEQ);
        chk("t6_pend_sat", pending, 3); chk("t6_err", flag_err, 1);
        repeat (3) begin cyc(); drive(0, 1, 0, 16'h0001, 1, FN_BEQ); end
        chk("t6_err_stall_fwd", br_stall, 1);
        cyc(); drive(0, 0, 0, 16'h0000, 1, FN_BEQ);
        chk("t6_drained", pending, 0); chk("t6_err_stall", br_stall, 1); chk("t6_err_sticky", flag_err, 1);
        cyc(); drive(0, 0, 0, 16'h0000, 1, 4'b0101);
        chk("t6_nonflag_ready", br_ready, 1);

        // Asynchronous reset mid-cycle with flags set and an op in flight
        cyc(); drive(1, 1, 1, 16'h0000, 0, FN_BEQ);
        cyc(); drive(1, 0, 0, 16'h0000, 0, FN_BEQ);
        cyc(); drive(0, 0, 0, 16'h0000, 0, FN_BEQ);
        chk("t1_pre_C1", C1, 1); chk("t1_pre_pend", pending, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_C0", C0, 1); chk("t1_C1", C1, 0); chk("t1_Z0", Z0, 1); chk("t1_Z1", Z1, 0);
        chk("t1_pend", pending, 0); chk("t1_err", flag_err, 0);
        cyc(); rst_n = 1'b1; #1;

        // Underflow from IDLE also latches the error; flags still load
        cyc(); drive(0, 1, 1, 16'h0000, 1, FN_BCS);
        chk("t6u_err_before", flag_err, 0);
        cyc(); drive(0, 0, 0, 16'h0000, 1, FN_BCS);
        chk("t6u_err", flag_err, 1); chk("t6u_pend", pending, 0);
        chk("t6u_C1", C1, 1); chk("t6u_Z1", Z1, 1); chk("t6u_stall", br_stall, 1);

        // Only reset leaves ERR
        #2 rst_n = 1'b0;
        #1 chk("t6u_rst_err", flag_err, 0);
        cyc(); rst_n = 1'b1; #1;
        cyc(); drive(0, 0, 0, 16'h0000, 1, FN_BCS);
        chk("t6u_ready_after_rst", br_ready, 1);

        repeat (2) cyc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
